// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : ctrl_pkg                                                         |
// | Purpose : Shared opcode values, ALU command encodings, branch codes, the   |
// |           packed control word and the ID/EX register state type used by    |
// |           the control decode stage.                                        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package ctrl_pkg;

  // Opcodes (low six bits of the opcode field)
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  // ALU command encodings
  localparam logic [3:0] EXE_ADD = 4'd0;
  localparam logic [3:0] EXE_SUB = 4'd2;
  localparam logic [3:0] EXE_AND = 4'd4;
  localparam logic [3:0] EXE_OR  = 4'd5;
  localparam logic [3:0] EXE_NOR = 4'd6;
  localparam logic [3:0] EXE_XOR = 4'd7;
  localparam logic [3:0] EXE_SHL = 4'd8;
  localparam logic [3:0] EXE_SRA = 4'd9;
  localparam logic [3:0] EXE_SRL = 4'd10;

  // Branch type codes
  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEZ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_JMP  = 2'd3;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       is_imm;
    logic       rd_as_src;
    logic [1:0] br_type;
  } ctrl_word_t;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ctrl_decode_lut                                                  |
// | Purpose : Pure combinational opcode -> control word lookup. Unlisted       |
// |           opcodes, or any set bit above [5:0], decode to an all-zero word  |
// |           (NOP) and raise illegal.                                         |
// | Ports   : opcode  in  OPCODE_W  instruction opcode                         |
// |           word    out ctrl_word_t decoded control bits                     |
// |           illegal out 1         opcode is not in the decode table          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ctrl_decode_lut
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_word_t          word,
  output logic                illegal
);

  logic upper_nz;

  generate
    if (OPCODE_W > 6) begin : g_upper
      assign upper_nz = |opcode[OPCODE_W-1:6];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (opcode[5:0])
      OP_NOP:  ;
      OP_ADD:  begin word.exe_cmd = EXE_ADD; word.wb_en = 1'b1; end
      OP_SUB:  begin word.exe_cmd = EXE_SUB; word.wb_en = 1'b1; end
      OP_AND:  begin word.exe_cmd = EXE_AND; word.wb_en = 1'b1; end
      OP_OR:   begin word.exe_cmd = EXE_OR;  word.wb_en = 1'b1; end
      OP_NOR:  begin word.exe_cmd = EXE_NOR; word.wb_en = 1'b1; end
      OP_XOR:  begin word.exe_cmd = EXE_XOR; word.wb_en = 1'b1; end
      OP_SLA, OP_SLL: begin word.exe_cmd = EXE_SHL; word.wb_en = 1'b1; end
      OP_SRA:  begin word.exe_cmd = EXE_SRA; word.wb_en = 1'b1; end
      OP_SRL:  begin word.exe_cmd = EXE_SRL; word.wb_en = 1'b1; end
      OP_ADDI: begin word.exe_cmd = EXE_ADD; word.wb_en = 1'b1; word.is_imm = 1'b1; end
      OP_SUBI: begin word.exe_cmd = EXE_SUB; word.wb_en = 1'b1; word.is_imm = 1'b1; end
      OP_LD: begin
        word.exe_cmd  = EXE_ADD;
        word.wb_en    = 1'b1;
        word.mem_read = 1'b1;
        word.is_imm   = 1'b1;
      end
      OP_ST: begin
        word.exe_cmd   = EXE_ADD;
        word.mem_write = 1'b1;
        word.is_imm    = 1'b1;
        word.rd_as_src = 1'b1;
      end
      OP_BEZ:  begin word.br_type = BR_BEZ; word.is_imm = 1'b1; end
      OP_BNE: begin
        word.br_type   = BR_BNE;
        word.is_imm    = 1'b1;
        word.rd_as_src = 1'b1;
      end
      OP_JMP:  begin word.br_type = BR_JMP; word.is_imm = 1'b1; end
      default: illegal = 1'b1;
    endcase
    // A set high bit makes the whole opcode unknown, whatever the low bits say
    if (upper_nz) begin
      word    = '0;
      illegal = 1'b1;
    end
  end

endmodule : ctrl_decode_lut
`default_nettype wire

// File: rtl/ctrl_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ctrl_decode_stage                                                |
// | Purpose : Decodes the ID-stage opcode into EXE/MEM/WB control bits and     |
// |           holds them in an ID/EX control register with valid/ready flow.   |
// |           A hazard registers a zeroed bubble and stalls upstream; flush    |
// |           kills the held entry. Counts hazard-stall cycles (saturating).   |
// | Config  : CTRL_ILLEGAL_OP_TRAP_EN - when defined, unknown opcodes raise a  |
// |           registered illegal flag alongside out_valid; otherwise illegal   |
// |           is tied 0 and unknown opcodes pass as NOP.                       |
// | Ports   : clk, rst_n (async active-low)                                    |
// |           in_valid/in_ready/opcode/hazard/flush  - ID side                 |
// |           out_valid/out_ready/exe_cmd/mem_read/mem_write/wb_en/is_imm/     |
// |           rd_as_src/br_type/illegal              - EXE side                |
// |           hazard_cnt                             - stall statistic         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int EXE_CMD_W = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 hazard,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 wb_en,
  output logic                 is_imm,
  output logic                 rd_as_src,
  output logic [1:0]           br_type,
  output logic                 illegal,
  output logic [CNT_W-1:0]     hazard_cnt
);

  ctrl_word_t       lut_word;
  logic             lut_illegal;
  logic             dec_illegal;
  logic             can_load;

  state_t           state_q, state_d;
  ctrl_word_t       word_q, word_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;

  ctrl_decode_lut #(
    .OPCODE_W (OPCODE_W)
  ) u_lut (
    .opcode  (opcode),
    .word    (lut_word),
    .illegal (lut_illegal)
  );

`ifdef CTRL_ILLEGAL_OP_TRAP_EN
  assign dec_illegal = lut_illegal;
`else
  logic unused_lut_illegal;
  assign unused_lut_illegal = lut_illegal;
  assign dec_illegal        = 1'b0;
`endif

  assign can_load = (state_q == ST_EMPTY) | out_ready;
  assign in_ready = can_load & ~hazard & ~flush;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d   = ST_EMPTY;
      word_d    = '0;
      illegal_d = 1'b0;
    end else if (in_valid && can_load) begin
      // A hazard still occupies the slot, but with an all-zero bubble
      state_d   = ST_FULL;
      word_d    = hazard ? '0 : lut_word;
      illegal_d = hazard ? 1'b0 : dec_illegal;
    end else if (!in_valid && out_ready) begin
      state_d   = ST_EMPTY;
      word_d    = '0;
      illegal_d = 1'b0;
    end
  end

  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if (in_valid && hazard && (hazard_cnt_q != {CNT_W{1'b1}})) begin
      hazard_cnt_d = hazard_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      word_q       <= '0;
      illegal_q    <= 1'b0;
      hazard_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      illegal_q    <= illegal_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  always_comb begin
    exe_cmd      = '0;
    exe_cmd[3:0] = word_q.exe_cmd;
  end

  assign out_valid  = (state_q == ST_FULL);
  assign mem_read   = word_q.mem_read;
  assign mem_write  = word_q.mem_write;
  assign wb_en      = word_q.wb_en;
  assign is_imm     = word_q.is_imm;
  assign rd_as_src  = word_q.rd_as_src;
  assign br_type    = word_q.br_type;
  assign illegal    = illegal_q;
  assign hazard_cnt = hazard_cnt_q;

endmodule : ctrl_decode_stage
`default_nettype wire
